id_memory_arbiter: RTL and testbench

// - Shares the single-port IDMemory between InstructionFetch (fetch port) and LoadStore (data port).
// - One outstanding memory transaction at a time; next grant can issue in the response cycle.
// - Data port has priority; a starvation counter forces a fetch grant. Watchdog flags a lost response.
// - Sits in Core between InstructionFetch/LoadStore and IDMemory.

---
 rtl/core_pkg.sv | 32 +++
 rtl/id_mem_arb_prio.sv | 42 ++++
 rtl/id_memory_arbiter.sv | 139 +++++++++++++
 tb/tb_id_memory_arbiter.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/core_pkg.sv
`default_nettype none
// ============================================================================
// core_pkg
// Shared types for the core memory path: arbiter state/owner encodings and
// the memory request bundle.
// Revision: 1.0
// ============================================================================
package core_pkg;

    localparam int XLEN = 32;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY_IF = 2'd1,
        BUSY_LS = 2'd2
    } arb_state_e;

    typedef enum logic [1:0] {
        NONE = 2'd0,
        IF   = 2'd1,
        LS   = 2'd2
    } arb_owner_e;

    typedef struct packed {
        logic            we;
        logic [3:0]      be;
        logic [XLEN-1:0] addr;
        logic [XLEN-1:0] wdata;
    } mem_req_t;

endpackage
`default_nettype wire

// File: rtl/id_mem_arb_prio.sv
`default_nettype none
// ============================================================================
// id_mem_arb_prio
// Winner select for the IDMemory arbiter: data port first, with a starvation
// counter that forces a fetch grant after STARVE_MAX back-to-back data grants.
// Revision: 1.0
// ============================================================================
module id_mem_arb_prio #(
    parameter int STARVE_MAX = 4
) (
    input  logic clk,
    input  logic rstn,
    input  logic if_req,
    input  logic ls_req,
    input  logic can_issue,
    output logic sel_if,
    output logic sel_ls
);

    localparam int              CNT_W   = $clog2(STARVE_MAX + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

    logic [CNT_W-1:0] starve_cnt;
    logic             force_if;

    assign force_if = if_req & (starve_cnt == CNT_MAX);
    assign sel_if   = can_issue & if_req & (force_if | ~ls_req);
    assign sel_ls   = can_issue & ls_req & ~force_if;

    // Counter only measures an unbroken wait; a withdrawn fetch request restarts it.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            starve_cnt <= '0;
        end else if (!if_req || sel_if) begin
            starve_cnt <= '0;
        end else if (sel_ls && (starve_cnt != CNT_MAX)) begin
            starve_cnt <= starve_cnt + 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/id_memory_arbiter.sv
`default_nettype none
// ============================================================================
// id_memory_arbiter
// Shares the single-port IDMemory between InstructionFetch and LoadStore with
// one outstanding transaction, response passthrough and a lost-response watchdog.
// Revision: 1.0
// ============================================================================
module id_memory_arbiter #(
    parameter int XLEN       = 32,
    parameter int STARVE_MAX = 4,
    parameter int TIMEOUT    = 64
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            if_req,
    input  logic [XLEN-1:0] if_addr,
    output logic            if_gnt,
    output logic            if_rvalid,
    output logic [XLEN-1:0] if_rdata,
    input  logic            ls_req,
    input  logic            ls_we,
    input  logic [3:0]      ls_be,
    input  logic [XLEN-1:0] ls_addr,
    input  logic [XLEN-1:0] ls_wdata,
    output logic            ls_gnt,
    output logic            ls_rvalid,
    output logic [XLEN-1:0] ls_rdata,
    output logic            mem_req,
    output logic            mem_we,
    output logic [3:0]      mem_be,
    output logic [XLEN-1:0] mem_addr,
    output logic [XLEN-1:0] mem_wdata,
    input  logic            mem_rvalid,
    input  logic [XLEN-1:0] mem_rdata,
    output logic            err
);

    import core_pkg::*;

    localparam logic [1:0]      ST_IDLE    = 2'(IDLE);
    localparam logic [1:0]      ST_BUSY_IF = 2'(BUSY_IF);
    localparam logic [1:0]      ST_BUSY_LS = 2'(BUSY_LS);
    localparam int              WD_W       = $clog2(TIMEOUT);
    localparam logic [WD_W-1:0] WD_LAST    = WD_W'(TIMEOUT - 1);

    logic [1:0]      state;
    logic [1:0]      state_nxt;
    logic [WD_W-1:0] wd_cnt;
    logic            busy;
    logic            can_issue;
    logic            sel_if;
    logic            sel_ls;
    logic            issue;
    logic            wd_expire;
    arb_owner_e      owner;

    assign busy      = (state != ST_IDLE);
    // Held reset also blocks issue so nothing leaks onto the memory bus.
    assign can_issue = rstn & ((state == ST_IDLE) | (busy & mem_rvalid));
    assign issue     = sel_if | sel_ls;
    assign wd_expire = busy & ~mem_rvalid & (wd_cnt == WD_LAST);

    id_mem_arb_prio #(
        .STARVE_MAX (STARVE_MAX)
    ) u_prio (
        .clk       (clk),
        .rstn      (rstn),
        .if_req    (if_req),
        .ls_req    (ls_req),
        .can_issue (can_issue),
        .sel_if    (sel_if),
        .sel_ls    (sel_ls)
    );

    assign if_gnt  = sel_if;
    assign ls_gnt  = sel_ls;
    assign mem_req = issue;

    always_comb begin
        mem_we    = 1'b0;
        mem_be    = 4'h0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (sel_ls) begin
            mem_we    = ls_we;
            mem_be    = ls_be;
            mem_addr  = ls_addr;
            mem_wdata = ls_wdata;
        end else if (sel_if) begin
            mem_be    = 4'hF;
            mem_addr  = if_addr;
        end
    end

    always_comb begin
        owner = NONE;
        case (state)
            ST_BUSY_IF: owner = IF;
            ST_BUSY_LS: owner = LS;
            default:    owner = NONE;
        endcase
    end

    assign if_rvalid = (owner == IF) & mem_rvalid;
    assign ls_rvalid = (owner == LS) & mem_rvalid;
    assign if_rdata  = if_rvalid ? mem_rdata : '0;
    assign ls_rdata  = ls_rvalid ? mem_rdata : '0;

    always_comb begin
        state_nxt = state;
        if (sel_ls) begin
            state_nxt = ST_BUSY_LS;
        end else if (sel_if) begin
            state_nxt = ST_BUSY_IF;
        end else if (busy && (mem_rvalid || wd_expire)) begin
            state_nxt = ST_IDLE;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state  <= ST_IDLE;
            wd_cnt <= '0;
            err    <= 1'b0;
        end else begin
            state <= state_nxt;
            if (issue || (busy && mem_rvalid) || wd_expire) begin
                wd_cnt <= '0;
            end else if (busy) begin
                wd_cnt <= wd_cnt + 1'b1;
            end
            if (wd_expire) begin
                err <= 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_id_memory_arbiter.sv
`default_nettype none
// ============================================================================
// tb_id_memory_arbiter
// Directed self-checking bench for the IDMemory arbiter.
// Revision: 1.0
// ============================================================================
module tb_id_memory_arbiter;

    localparam int XLEN = 32;

    logic            clk = 1'b0;
    logic            rstn;
    logic            if_req;
    logic [XLEN-1:0] if_addr;
    logic            if_gnt;
    logic            if_rvalid;
    logic [XLEN-1:0] if_rdata;
    logic            ls_req;
    logic            ls_we;
    logic [3:0]      ls_be;
    logic [XLEN-1:0] ls_addr;
    logic [XLEN-1:0] ls_wdata;
    logic            ls_gnt;
    logic            ls_rvalid;
    logic [XLEN-1:0] ls_rdata;
    logic            mem_req;
    logic            mem_we;
    logic [3:0]      mem_be;
    logic [XLEN-1:0] mem_addr;
    logic [XLEN-1:0] mem_wdata;
    logic            mem_rvalid;
    logic [XLEN-1:0] mem_rdata;
    logic            err;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    id_memory_arbiter #(
        .XLEN       (XLEN),
        .STARVE_MAX (4),
        .TIMEOUT    (8)
    ) dut (
        .clk        (clk),
        .rstn       (rstn),
        .if_req     (if_req),
        .if_addr    (if_addr),
        .if_gnt     (if_gnt),
        .if_rvalid  (if_rvalid),
        .if_rdata   (if_rdata),
        .ls_req     (ls_req),
        .ls_we      (ls_we),
        .ls_be      (ls_be),
        .ls_addr    (ls_addr),
        .ls_wdata   (ls_wdata),
        .ls_gnt     (ls_gnt),
        .ls_rvalid  (ls_rvalid),
        .ls_rdata   (ls_rdata),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_be     (mem_be),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata),
        .err        (err)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rstn = 1'b0; if_req = 1'b1; ls_req = 1'b1;
        if_addr = 32'h10; ls_addr = 32'h20;
        tick();
        #2;
        n_cmp++;
        if ({if_gnt, ls_gnt, mem_req, if_rvalid, ls_rvalid, err} !== 6'b0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %b want 000000", {if_gnt, ls_gnt, mem_req, if_rvalid, ls_rvalid, err});
        end
        n_cmp++;
        if ({if_rdata, ls_rdata} !== 64'h0) begin
            n_fail++; $display("FAIL reset_rdata: got %h want 0", {if_rdata, ls_rdata});
        end
        tick();
        rstn = 1'b1;
        #2;
        n_cmp++;
        if ({ls_gnt, if_gnt, mem_addr} !== {2'b10, 32'h20}) begin
            n_fail++; $display("FAIL reset_first_gnt: got ls=%b if=%b addr=%h want ls=1 if=0 addr=20", ls_gnt, if_gnt, mem_addr);
        end
        tick();
        if_req = 1'b0; ls_req = 1'b0;
        mem_rvalid = 1'b1; mem_rdata = 32'h55;
        #2;
        n_cmp++;
        if ({ls_rvalid, ls_rdata} !== {1'b1, 32'h55}) begin
            n_fail++; $display("FAIL reset_first_resp: got v=%b d=%h want v=1 d=55", ls_rvalid, ls_rdata);
        end
        tick();
        mem_rvalid = 1'b0;
    endtask

    task automatic test_if_only();
        if_req = 1'b1; if_addr = 32'h100;
        #2;
        n_cmp++;
        if ({if_gnt, ls_gnt, mem_req, mem_we, mem_be, mem_addr, mem_wdata} !== {4'b1010, 4'hF, 32'h100, 32'h0}) begin
            n_fail++; $display("FAIL if_issue: got gnt=%b mem we=%b be=%h a=%h wd=%h want gnt=1 we=0 be=f a=100 wd=0",
                               if_gnt, mem_we, mem_be, mem_addr, mem_wdata);
        end
        tick();
        if_req = 1'b0;
        #2;
        n_cmp++;
        if ({if_rvalid, mem_req} !== 2'b00) begin
            n_fail++; $display("FAIL if_wait: got rvalid=%b mem_req=%b want 0 0", if_rvalid, mem_req);
        end
        tick();
        mem_rvalid = 1'b1; mem_rdata = 32'hDEADBEEF;
        #2;
        n_cmp++;
        if ({if_rvalid, if_rdata, ls_rvalid, ls_rdata} !== {1'b1, 32'hDEADBEEF, 1'b0, 32'h0}) begin
            n_fail++; $display("FAIL if_resp: got if=%b/%h ls=%b/%h want if=1/deadbeef ls=0/0", if_rvalid, if_rdata, ls_rvalid, ls_rdata);
        end
        tick();
        mem_rvalid = 1'b0;
    endtask

    task automatic test_store();
        ls_req = 1'b1; ls_we = 1'b1; ls_be = 4'b0011; ls_addr = 32'h2004; ls_wdata = 32'h1234;
        #2;
        n_cmp++;
        if ({ls_gnt, mem_req, mem_we, mem_be, mem_addr, mem_wdata} !== {3'b111, 4'b0011, 32'h2004, 32'h1234}) begin
            n_fail++; $display("FAIL store_issue: got gnt=%b we=%b be=%b a=%h wd=%h want 1 1 0011 2004 1234",
                               ls_gnt, mem_we, mem_be, mem_addr, mem_wdata);
        end
        tick();
        ls_req = 1'b0; ls_we = 1'b0;
        mem_rvalid = 1'b1; mem_rdata = 32'h0;
        #2;
        n_cmp++;
        if ({ls_rvalid, if_rvalid} !== 2'b10) begin
            n_fail++; $display("FAIL store_ack: got ls=%b if=%b want ls=1 if=0", ls_rvalid, if_rvalid);
        end
        tick();
        // Stray response while idle must not be forwarded
        #2;
        n_cmp++;
        if ({ls_rvalid, if_rvalid} !== 2'b00) begin
            n_fail++; $display("FAIL idle_rvalid: got ls=%b if=%b want 0 0", ls_rvalid, if_rvalid);
        end
        tick();
        mem_rvalid = 1'b0;
    endtask

    task automatic test_starvation();
        logic [9:0] exp_if;
        logic       prev_if;
        exp_if = 10'b1000010000;
        prev_if = 1'b0;
        if_req = 1'b1; if_addr = 32'h40;
        ls_req = 1'b1; ls_addr = 32'h80; ls_we = 1'b0; ls_be = 4'hF;
        for (int i = 0; i < 10; i++) begin
            mem_rvalid = (i != 0);
            mem_rdata  = 32'hA000 + i;
            #2;
            n_cmp++;
            if ({if_gnt, ls_gnt} !== {exp_if[i], ~exp_if[i]}) begin
                n_fail++; $display("FAIL starve_gnt[%0d]: got if=%b ls=%b want if=%b ls=%b", i, if_gnt, ls_gnt, exp_if[i], ~exp_if[i]);
            end
            if (i != 0) begin
                n_cmp++;
                if ({if_rvalid, ls_rvalid} !== {prev_if, ~prev_if}) begin
                    n_fail++; $display("FAIL starve_resp[%0d]: got if=%b ls=%b want if=%b ls=%b", i, if_rvalid, ls_rvalid, prev_if, ~prev_if);
                end
            end
            prev_if = exp_if[i];
            tick();
        end
        if_req = 1'b0; ls_req = 1'b0;
        mem_rvalid = 1'b1;
        tick();
        mem_rvalid = 1'b0;
    endtask

    task automatic test_back_to_back();
        ls_req = 1'b1; ls_we = 1'b0; ls_addr = 32'h300;
        #2;
        n_cmp++;
        if (ls_gnt !== 1'b1) begin
            n_fail++; $display("FAIL b2b_first_gnt: got %b want 1", ls_gnt);
        end
        tick();
        ls_addr = 32'h304; mem_rvalid = 1'b1; mem_rdata = 32'hCAFE0001;
        #2;
        n_cmp++;
        if ({ls_rvalid, ls_rdata, ls_gnt, mem_addr} !== {1'b1, 32'hCAFE0001, 1'b1, 32'h304}) begin
            n_fail++; $display("FAIL b2b_same_cycle: got v=%b d=%h gnt=%b a=%h want 1 cafe0001 1 304", ls_rvalid, ls_rdata, ls_gnt, mem_addr);
        end
        tick();
        ls_req = 1'b0; mem_rdata = 32'hCAFE0002;
        #2;
        n_cmp++;
        if ({ls_rvalid, ls_rdata, ls_gnt} !== {1'b1, 32'hCAFE0002, 1'b0}) begin
            n_fail++; $display("FAIL b2b_second_resp: got v=%b d=%h gnt=%b want 1 cafe0002 0", ls_rvalid, ls_rdata, ls_gnt);
        end
        tick();
        mem_rvalid = 1'b0;
    endtask

    task automatic test_timeout();
        if_req = 1'b1; if_addr = 32'h200;
        #2;
        n_cmp++;
        if (if_gnt !== 1'b1) begin
            n_fail++; $display("FAIL to_issue: got %b want 1", if_gnt);
        end
        tick();
        if_req = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            #2;
            n_cmp++;
            if ({err, if_rvalid} !== 2'b00) begin
                n_fail++; $display("FAIL to_busy[%0d]: got err=%b rvalid=%b want 0 0", k, err, if_rvalid);
            end
            tick();
        end
        if_req = 1'b1; if_addr = 32'h400;
        #2;
        n_cmp++;
        if ({err, if_gnt, mem_addr} !== {2'b11, 32'h400}) begin
            n_fail++; $display("FAIL to_expired: got err=%b gnt=%b a=%h want 1 1 400", err, if_gnt, mem_addr);
        end
        tick();
        if_req = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h77;
        #2;
        n_cmp++;
        if ({err, if_rvalid, if_rdata} !== {2'b11, 32'h77}) begin
            n_fail++; $display("FAIL to_sticky: got err=%b v=%b d=%h want 1 1 77", err, if_rvalid, if_rdata);
        end
        tick();
        mem_rvalid = 1'b0;
    endtask

    task automatic test_reset_mid();
        ls_req = 1'b1; ls_addr = 32'h500;
        tick();
        ls_req = 1'b0;
        rstn = 1'b0;
        #2;
        n_cmp++;
        if (err !== 1'b0) begin
            n_fail++; $display("FAIL rst_clears_err: got %b want 0", err);
        end
        tick();
        rstn = 1'b1;
        tick();
        mem_rvalid = 1'b1; mem_rdata = 32'h99;
        #2;
        n_cmp++;
        if ({ls_rvalid, if_rvalid, ls_rdata} !== {2'b00, 32'h0}) begin
            n_fail++; $display("FAIL stale_rvalid: got ls=%b if=%b d=%h want 0 0 0", ls_rvalid, if_rvalid, ls_rdata);
        end
        tick();
        mem_rvalid = 1'b0;
    endtask

    initial begin
        rstn = 1'b0; if_req = 1'b0; if_addr = '0;
        ls_req = 1'b0; ls_we = 1'b0; ls_be = 4'h0; ls_addr = '0; ls_wdata = '0;
        mem_rvalid = 1'b0; mem_rdata = '0;
        test_reset();
        test_if_only();
        test_store();
        test_starvation();
        test_back_to_back();
        test_timeout();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
